uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync2.sv | 23 ++
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and default bit timing
package uart_pkg;

   localparam int CLKS_PER_BIT_DEFAULT = 87;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      CLEANUP   = 3'd4,
      WAIT_IDLE = 3'd5
   } rx_state_t;

   // Cycle offset of the start-bit check from the first low sample.
   function automatic int half_bit(input int clks_per_bit);
      return (clks_per_bit - 1) / 2;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer with selectable reset level
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and frame-error detect
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       i_Clock,
   input  logic       i_Rst_n,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Frame_Err,
   output logic       o_Rx_Active
);

   localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);
   localparam logic [7:0] HALF_CNT = 8'(half_bit(CLKS_PER_BIT));

   logic       rx_sync;
   rx_state_t  state;
   logic [7:0] clk_cnt;
   logic [2:0] bit_idx;
   logic [7:0] shift;
   logic [7:0] rx_byte;
   logic       rx_dv;
   logic       frame_err;
   logic       rx_active;

   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clk   (i_Clock),
      .rst_n (i_Rst_n),
      .d     (i_Rx_Serial),
      .q     (rx_sync)
   );

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state     <= IDLE;
         clk_cnt   <= 8'd0;
         bit_idx   <= 3'd0;
         shift     <= 8'd0;
         rx_byte   <= 8'd0;
         rx_dv     <= 1'b0;
         frame_err <= 1'b0;
         rx_active <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               clk_cnt   <= 8'd0;
               bit_idx   <= 3'd0;
               rx_dv     <= 1'b0;
               frame_err <= 1'b0;
               if (!rx_sync) state <= START;
            end

            // A start bit must still be low half a bit later, else it was a glitch.
            START: begin
               if (clk_cnt == HALF_CNT) begin
                  clk_cnt <= 8'd0;
                  if (!rx_sync) begin
                     state     <= DATA;
                     rx_active <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 8'd1;
               end
            end

            DATA: begin
               if (clk_cnt == LAST_CNT) begin
                  clk_cnt        <= 8'd0;
                  shift[bit_idx] <= rx_sync;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= 3'd0;
                     state   <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 8'd1;
               end
            end

            STOP: begin
               if (clk_cnt == LAST_CNT) begin
                  clk_cnt <= 8'd0;
                  if (rx_sync) begin
                     rx_byte <= shift;
                     rx_dv   <= 1'b1;
                     state   <= CLEANUP;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_IDLE;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 8'd1;
               end
            end

            CLEANUP: begin
               rx_dv     <= 1'b0;
               frame_err <= 1'b0;
               rx_active <= 1'b0;
               state     <= IDLE;
            end

            // A held-low line (break) must return high before a new frame can start.
            WAIT_IDLE: begin
               rx_dv     <= 1'b0;
               frame_err <= 1'b0;
               rx_active <= 1'b0;
               if (rx_sync) state <= IDLE;
            end

            default: begin
               state     <= IDLE;
               clk_cnt   <= 8'd0;
               bit_idx   <= 3'd0;
               rx_dv     <= 1'b0;
               frame_err <= 1'b0;
               rx_active <= 1'b0;
            end
         endcase
      end
   end

   assign o_Rx_DV        = rx_dv;
   assign o_Rx_Byte      = rx_byte;
   assign o_Rx_Frame_Err = frame_err;
   assign o_Rx_Active    = rx_active;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at default and 4 clk/bit builds
module tb_uart_rx;
   import uart_pkg::*;

   typedef struct {
      logic [7:0] b;
      int         fall;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_a = 1'b1;
   logic       rx_b = 1'b1;
   logic       dv_a, ferr_a, act_a, dv_b, ferr_b, act_b;
   logic [7:0] byte_a, byte_b;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_fall_a = 0, last_fall_b = 0;
   int dv_cnt_a = 0, dv_cnt_b = 0, ferr_cnt_a = 0, ferr_cnt_b = 0;
   int act_rise_a = 0, act_rise_b = 0;
   int snap;
   logic prev_dv_a = 0, prev_ferr_a = 0, prev_act_a = 0;
   logic prev_dv_b = 0, prev_ferr_b = 0, prev_act_b = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a, e_b;

   uart_rx dut_a (
      .i_Clock        (clk),
      .i_Rst_n        (rst_n),
      .i_Rx_Serial    (rx_a),
      .o_Rx_DV        (dv_a),
      .o_Rx_Byte      (byte_a),
      .o_Rx_Frame_Err (ferr_a),
      .o_Rx_Active    (act_a)
   );

   uart_rx #(.CLKS_PER_BIT(4)) dut_b (
      .i_Clock        (clk),
      .i_Rst_n        (rst_n),
      .i_Rx_Serial    (rx_b),
      .o_Rx_DV        (dv_b),
      .o_Rx_Byte      (byte_b),
      .o_Rx_Frame_Err (ferr_b),
      .o_Rx_Active    (act_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_lat(input string tag, input int got, input int exp);
      check(tag, (got >= exp - 1 && got <= exp + 1) ? exp : got, exp);
   endtask

   // Expected cycles from line fall to DV, and to Active rise.
   function automatic int dv_lat(input int c);
      return 2 + (c - 1) / 2 + 9 * c + 1;
   endfunction

   function automatic int act_lat(input int c);
      return 2 + (c - 1) / 2 + 1;
   endfunction

   always @(negedge clk) begin
      if (dv_a) begin
         dv_cnt_a++;
         check("a_dv_width", prev_dv_a, 0);
         check("a_dv_excl", ferr_a, 0);
         if (q_a.size() == 0) begin
            check("a_dv_unexpected", 1, 0);
         end else begin
            e_a = q_a.pop_front();
            check("a_byte", byte_a, e_a.b);
            check_lat("a_dv_lat", cyc - e_a.fall, dv_lat(87));
         end
      end
      if (ferr_a) begin
         ferr_cnt_a++;
         check("a_ferr_width", prev_ferr_a, 0);
      end
      if (act_a && !prev_act_a) begin
         act_rise_a++;
         check_lat("a_act_lat", cyc - last_fall_a, act_lat(87));
      end
      prev_dv_a   = dv_a;
      prev_ferr_a = ferr_a;
      prev_act_a  = act_a;
   end

   always @(negedge clk) begin
      if (dv_b) begin
         dv_cnt_b++;
         check("b_dv_width", prev_dv_b, 0);
         check("b_dv_excl", ferr_b, 0);
         if (q_b.size() == 0) begin
            check("b_dv_unexpected", 1, 0);
         end else begin
            e_b = q_b.pop_front();
            check("b_byte", byte_b, e_b.b);
            check_lat("b_dv_lat", cyc - e_b.fall, dv_lat(4));
         end
      end
      if (ferr_b) begin
         ferr_cnt_b++;
         check("b_ferr_width", prev_ferr_b, 0);
      end
      if (act_b && !prev_act_b) begin
         act_rise_b++;
         check_lat("b_act_lat", cyc - last_fall_b, act_lat(4));
      end
      prev_dv_b   = dv_b;
      prev_ferr_b = ferr_b;
      prev_act_b  = act_b;
   end

   task automatic drive(input bit sel, input logic v, input int n);
      if (sel) rx_b = v;
      else     rx_a = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop_v, input bit push);
      int   c;
      exp_t e;
      c = sel ? 4 : 87;
      if (sel) last_fall_b = cyc;
      else     last_fall_a = cyc;
      if (push) begin
         e.b    = b;
         e.fall = cyc;
         if (sel) q_b.push_back(e);
         else     q_a.push_back(e);
      end
      drive(sel, 1'b0, c);
      for (int i = 0; i < 8; i++) drive(sel, b[i], c);
      drive(sel, stop_v, c);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] abort_byte;
      abort_byte = 8'h81;

      repeat (3) @(posedge clk);
      #1;
      check("rst_dv", dv_a, 0);
      check("rst_ferr", ferr_a, 0);
      check("rst_act", act_a, 0);
      check("rst_byte", byte_a, 0);
      check("rst_byte_b", byte_b, 0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      send_frame(0, 8'hA5, 1'b1, 1);
      drive(0, 1'b1, 20);
      check("a5_dv_cnt", dv_cnt_a, 1);
      check("a5_byte", byte_a, 8'hA5);
      check("a5_ferr_cnt", ferr_cnt_a, 0);

      send_frame(0, 8'h00, 1'b1, 1);
      send_frame(0, 8'hFF, 1'b1, 1);
      drive(0, 1'b1, 20);
      check("b2b_dv_cnt", dv_cnt_a, 3);
      check("b2b_byte", byte_a, 8'hFF);

      snap = act_rise_a;
      drive(0, 1'b0, 20);
      drive(0, 1'b1, 200);
      check("glitch_act", act_rise_a, snap);
      check("glitch_dv_cnt", dv_cnt_a, 3);
      check("glitch_ferr_cnt", ferr_cnt_a, 0);
      check("glitch_state", dut_a.state, IDLE);

      send_frame(0, 8'h3C, 1'b0, 0);
      drive(0, 1'b0, 300);
      check("break_act", act_a, 0);
      drive(0, 1'b1, 50);
      check("ferr_cnt", ferr_cnt_a, 1);
      check("ferr_dv_cnt", dv_cnt_a, 3);
      check("ferr_byte_kept", byte_a, 8'hFF);
      check("ferr_state", dut_a.state, IDLE);
      send_frame(0, 8'h5A, 1'b1, 1);
      drive(0, 1'b1, 20);
      check("after_ferr_dv_cnt", dv_cnt_a, 4);
      check("after_ferr_byte", byte_a, 8'h5A);

      last_fall_a = cyc;
      drive(0, 1'b0, 87);
      for (int i = 0; i < 4; i++) drive(0, abort_byte[i], 87);
      drive(0, abort_byte[4], 40);
      check("pre_rst_act", act_a, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_dv", dv_a, 0);
      check("mid_rst_ferr", ferr_a, 0);
      check("mid_rst_act", act_a, 0);
      check("mid_rst_byte", byte_a, 0);
      rx_a = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(0, 1'b1, 20);
      check("abort_dv_cnt", dv_cnt_a, 4);
      send_frame(0, 8'h7E, 1'b1, 1);
      drive(0, 1'b1, 20);
      check("post_rst_dv_cnt", dv_cnt_a, 5);
      check("post_rst_byte", byte_a, 8'h7E);
      check("post_rst_ferr_cnt", ferr_cnt_a, 1);

      send_frame(1, 8'hC3, 1'b1, 1);
      send_frame(1, 8'h5A, 1'b1, 1);
      drive(1, 1'b1, 20);
      check("b_dv_cnt", dv_cnt_b, 2);
      check("b_last_byte", byte_b, 8'h5A);
      check("b_ferr_cnt", ferr_cnt_b, 0);
      check("b_act_rises", act_rise_b, 2);

      check("a_queue_empty", q_a.size(), 0);
      check("b_queue_empty", q_b.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
